lsu_tlb_rd_ctl: RTL
===================

Name: lsu_tlb_rd_ctl

Overview:
- Per-thread controller for diagnostic DTLB reads: ASI tag-read and data-read accesses.
- Arbitrates pending requests from the 4 strands round-robin and drives the TLB read strobe, entry index and tag/data select into the TLB read datapath.
- Waits a fixed read latency, captures the formatted 64-bit read data and its parity status, then returns a one-cycle response to the winning strand.
- Sits between the per-thread ASI decode and the TLB read-format datapath.

Parameters:
NTHR, 4, number of requesting strands (one request bit each)
ENTRY_W, 6, TLB entry index width (64 entries)
RD_LAT, 2, cycles from tlb_rd_vld to valid tlb_rd_data (RD_LAT >= 1)

Ports:
rclk  in  1  clock
rst  in  1  synchronous active-high reset
req_vld  in  NTHR  per-strand read request; level, held until that strand's rsp_vld
req_is_data  in  NTHR  per-strand select: 1 = TTE data read, 0 = TTE tag read
req_entry  in  NTHR*ENTRY_W  per-strand entry index; strand i occupies bits [i*ENTRY_W +: ENTRY_W]
tlb_busy  in  1  TLB occupied by a write or demap; blocks new grants only
tlb_rd_data  in  64  formatted tag/data read result from the TLB datapath
tte_data_parity_error  in  1  data parity error flag for the current read
tte_tag_parity_error  in  1  tag parity error flag for the current read
tlb_rd_vld  out  1  one-cycle TLB read strobe
tlb_rd_entry  out  ENTRY_W  entry index being read
tlb_data_rd_sel  out  1  tag/data select into the datapath's read mux (1 = data)
rsp_vld  out  NTHR  one-hot, one-cycle response to the served strand
rsp_data  out  64  registered read result; valid when rsp_vld != 0
rsp_par_err  out  1  parity error for the response; valid with rsp_vld
ctl_busy  out  1  high whenever the controller is not in IDLE

Behaviour:
- Reset (synchronous, rst high at a rclk edge):
  - All outputs go to 0 and the state goes to IDLE.
  - The round-robin pointer is set to strand 0, so strand 0 has highest priority first.
  - Reset mid-operation abandons the access: no rsp_vld is produced, and any capture is discarded.
- States:
  - IDLE:
    - A strand is eligible if req_vld[i]=1 and it is not the strand served in the immediately preceding RESP.
    - If tlb_busy=0 and at least one strand is eligible, grant the first eligible strand at or after the pointer, wrapping modulo NTHR.
    - On grant: latch the strand id, req_is_data and req_entry; advance the pointer to grant+1 (mod NTHR); go to ISSUE.
    - If tlb_busy=1, stay in IDLE with no grant.
  - ISSUE (1 cycle): tlb_rd_vld=1; tlb_rd_entry and tlb_data_rd_sel come from the latched values; go to WAIT.
  - WAIT (RD_LAT cycles):
    - A down-counter is loaded with RD_LAT-1 on entry to WAIT.
    - In the WAIT cycle where the counter is 0: capture tlb_rd_data into rsp_data, and capture the parity flag selected by the latched is_data (data flag if 1, tag flag if 0). Then go to RESP.
  - RESP (1 cycle): rsp_vld[strand]=1; rsp_data and rsp_par_err are held; go to IDLE.
- tlb_rd_entry and tlb_data_rd_sel:
  - Stable from ISSUE through RESP.
  - Hold their last value in IDLE, except at reset, where they are 0.
- Latency: from the IDLE grant cycle (cycle 0), tlb_rd_vld is in cycle 1 and rsp_vld is in cycle RD_LAT+2 (cycle 4 at default).
- Throughput: one access per RD_LAT+3 cycles. The next grant is possible in the cycle after RESP.
- tlb_busy is ignored once an access has been granted.
- Requests are not cancellable. A strand deasserting req_vld before its response is a protocol violation; the controller still completes the access and responds.
- Simultaneous requests from all strands are served in strict rotation 0,1,2,3,0,...
- rsp_data and rsp_par_err retain their values after RESP until the next capture.
- ctl_busy = (state != IDLE).

Optional Feature:
Macro: LSU_TLBRD_PARCHK_EN
- Defined: rsp_par_err is captured as described in Behaviour.
- Undefined: rsp_par_err is constant 0, the parity inputs are unused, and there is no capture flop for them.

Test Plan:
- Reset: hold rst for 2 cycles with all req_vld=1 -> all outputs 0, no tlb_rd_vld. After release, the first grant goes to strand 0.
- Single read: req_vld=4'b0100, req_is_data[2]=1, entry 6'd37, tlb_rd_data=64'hDEAD_BEEF_0123_4567 in cycle 3 -> tlb_rd_vld in cycle 1 with entry 37 and sel=1; rsp_vld=4'b0100 in cycle 4 with that data.
- Round-robin: req_vld=4'b1111 held, each strand dropping its request after its response -> responses in order 0,1,2,3, each 5 cycles apart.
- tlb_busy held high for 3 cycles with req_vld[1]=1 -> no tlb_rd_vld during those cycles; grant in the first cycle busy=0. Busy asserted after grant -> no effect on the access.
- Parity: tag read with tte_tag_parity_error=1 and tte_data_parity_error=0 in the capture cycle -> rsp_par_err=1. Data read with the same inputs -> rsp_par_err=0. With the macro undefined -> rsp_par_err=0 for both.
- Reset in WAIT: assert rst in cycle 2 of an access -> no rsp_vld, state IDLE, pointer reset to strand 0.

Source files
------------

// File: rtl/lsu_tlb_rd_ctl.sv
// Diagnostic DTLB tag/data read controller: round-robin strand arbitration, fixed-latency read, one-cycle response.
// Optional macro LSU_TLBRD_PARCHK_EN enables capture of the selected tag/data parity error into rsp_par_err.
module lsu_tlb_rd_ctl #(
  parameter int NTHR    = 4,
  parameter int ENTRY_W = 6,
  parameter int RD_LAT  = 2
) (
  input  logic                    rclk,
  input  logic                    rst,
  input  logic [NTHR-1:0]         req_vld,
  input  logic [NTHR-1:0]         req_is_data,
  input  logic [NTHR*ENTRY_W-1:0] req_entry,
  input  logic                    tlb_busy,
  input  logic [63:0]             tlb_rd_data,
  input  logic                    tte_data_parity_error,
  input  logic                    tte_tag_parity_error,
  output logic                    tlb_rd_vld,
  output logic [ENTRY_W-1:0]      tlb_rd_entry,
  output logic                    tlb_data_rd_sel,
  output logic [NTHR-1:0]         rsp_vld,
  output logic [63:0]             rsp_data,
  output logic                    rsp_par_err,
  output logic                    ctl_busy
);

  localparam int PTR_W = (NTHR > 1) ? $clog2(NTHR) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_id_q, gnt_id_d;
  logic               is_data_q, is_data_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               excl_q, excl_d;
  logic               rd_vld_q, rd_vld_d;
  logic [NTHR-1:0]    rsp_vld_q, rsp_vld_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;

  logic [NTHR-1:0]    elig_s;
  logic [PTR_W-1:0]   idx_s;
  logic [PTR_W-1:0]   sel_s;
  logic               pick_s;
  logic               found_s;

`ifdef LSU_TLBRD_PARCHK_EN
  logic par_q, par_d;

  function automatic logic sel_parity(input logic is_data, input logic data_pe, input logic tag_pe);
    return is_data ? data_pe : tag_pe;
  endfunction
`else
  logic unused_par_s;
  assign unused_par_s = tte_data_parity_error ^ tte_tag_parity_error;
`endif

  // Round-robin pick: the strand just served in RESP sits out the following IDLE cycle.
  always_comb begin
    elig_s  = '0;
    idx_s   = '0;
    pick_s  = 1'b0;
    sel_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NTHR; i++) begin
      elig_s[i] = req_vld[i] & ~(excl_q & (gnt_id_q == PTR_W'(i)));
    end
    for (int k = 0; k < NTHR; k++) begin
      idx_s   = PTR_W'((int'(ptr_q) + k) % NTHR);
      pick_s  = elig_s[idx_s] & ~found_s;
      sel_s   = pick_s ? idx_s : sel_s;
      found_s = found_s | pick_s;
    end
  end

  // Next-state and registered-output computation for the read sequence.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_id_d   = gnt_id_q;
    is_data_d  = is_data_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    excl_d     = 1'b0;
    rd_vld_d   = 1'b0;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
`ifdef LSU_TLBRD_PARCHK_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!tlb_busy && found_s) begin
          gnt_id_d  = sel_s;
          is_data_d = req_is_data[sel_s];
          entry_d   = req_entry[int'(sel_s)*ENTRY_W +: ENTRY_W];
          ptr_d     = (sel_s == PTR_W'(NTHR-1)) ? '0 : sel_s + 1'b1;
          rd_vld_d  = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d   = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(RD_LAT-1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = tlb_rd_data;
`ifdef LSU_TLBRD_PARCHK_EN
          par_d      = sel_parity(is_data_q, tte_data_parity_error, tte_tag_parity_error);
`endif
          rsp_vld_d  = NTHR'(1) << gnt_id_q;
          state_d    = RESP;
        end else begin
          cnt_d      = cnt_q - 1'b1;
        end
      end
      RESP: begin
        excl_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      is_data_q  <= 1'b0;
      entry_q    <= '0;
      cnt_q      <= '0;
      excl_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rsp_vld_q  <= '0;
      rsp_data_q <= 64'h0;
      busy_q     <= 1'b0;
`ifdef LSU_TLBRD_PARCHK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      is_data_q  <= is_data_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      excl_q     <= excl_d;
      rd_vld_q   <= rd_vld_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      busy_q     <= busy_d;
`ifdef LSU_TLBRD_PARCHK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tlb_rd_vld      = rd_vld_q;
  assign tlb_rd_entry    = entry_q;
  assign tlb_data_rd_sel = is_data_q;
  assign rsp_vld         = rsp_vld_q;
  assign rsp_data        = rsp_data_q;
  assign ctl_busy        = busy_q;
`ifdef LSU_TLBRD_PARCHK_EN
  assign rsp_par_err     = par_q;
`else
  assign rsp_par_err     = 1'b0;
`endif

endmodule
